// File: rtl/bank_read_return.sv
// Read-return path for the 4-bank memory: tracks issued reads by bank tag in
// issue order and forwards each bank's response with a 1-cycle registered strobe.
module bank_read_return #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rd_issue,
    input  logic [3:0]                i_bank_sel,
    input  logic [3:0]                i_bank_rvalid,
    input  logic [4*DATA_WIDTH-1:0]   i_bank_rdata,
    output logic [DATA_WIDTH-1:0]     o_rdata,
    output logic                      o_rvalid,
    output logic [1:0]                o_rbank,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_outstanding,
    output logic                      o_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    function automatic logic is_onehot(input logic [3:0] v);
        return (v == 4'b1000) || (v == 4'b0100) || (v == 4'b0010) || (v == 4'b0001);
    endfunction

    // Inverse of the bank-enable decoder: bit3 is bank 0, bit0 is bank 3.
    function automatic logic [1:0] enc_bank(input logic [3:0] v);
        case (v)
            4'b1000: return 2'd0;
            4'b0100: return 2'd1;
            4'b0010: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    logic [1:0]            tag_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rbank_q, rbank_d;
    logic                  err_q, err_d;

    logic                  sel_ok, rv_onehot, rv_any, is_full, is_empty;
    logic                  push_req, push_ok, pop_ok;
    logic [1:0]            rv_bank;
    logic [DATA_WIDTH-1:0] rv_slice;

    always_comb begin
        rv_slice = '0;
        for (int b = 0; b < 4; b++) begin
            if (i_bank_rvalid[b]) begin
                rv_slice = i_bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        sel_ok    = is_onehot(i_bank_sel);
        rv_onehot = is_onehot(i_bank_rvalid);
        rv_any    = |i_bank_rvalid;
        rv_bank   = enc_bank(i_bank_rvalid);
        is_full   = (count_q == CNT_FULL);
        is_empty  = (count_q == '0);

        pop_ok   = rv_onehot && !is_empty;
        push_req = i_rd_issue && sel_ok;
        // A pop in the same cycle frees a slot, so a push at full is still accepted.
        push_ok  = push_req && (!is_full || pop_ok);

        err_d = (i_rd_issue && !sel_ok)
              || (push_req && !push_ok)
              || (rv_any && !rv_onehot)
              || (rv_onehot && is_empty)
              || (pop_ok && (rv_bank != tag_mem[rd_ptr_q]));

        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        full_d   = (count_d == CNT_FULL);
        empty_d  = (count_d == '0);

        rvalid_d = pop_ok;
        rdata_d  = pop_ok ? rv_slice : rdata_q;
        rbank_d  = pop_ok ? rv_bank  : rbank_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rbank_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rbank_q  <= rbank_d;
            err_q    <= err_d;
        end
    end

    // Tag storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            tag_mem[wr_ptr_q] <= enc_bank(i_bank_sel);
        end
    end

    assign o_rdata       = rdata_q;
    assign o_rvalid      = rvalid_q;
    assign o_rbank       = rbank_q;
    assign o_full        = full_q;
    assign o_empty       = empty_q;
    assign o_outstanding = count_q;
    assign o_err         = err_q;

endmodule
